// File: rtl/jstk_poll_ctrl.sv
// Periodic joystick poll controller: frames five SPI bytes under ss, decodes X/Y/buttons.
// Optional macro JSTK_DEADZONE_EN snaps decoded X/Y in 480..520 to the 500 centre value.
module jstk_poll_ctrl #(
    parameter int POLL_CYC    = 1_000_000,
    parameter int SETUP_CYC   = 1500,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_tx_o,
    input  logic        spi_done_i,
    input  logic [7:0]  spi_rx_i,
    output logic        ss_o,
    input  logic [1:0]  led_cmd_i,
    output logic [10:0] velocity_o,
    output logic [9:0]  steer_o,
    output logic [2:0]  buttons_o,
    output logic        sample_valid_o,
    output logic        timeout_err_o
);
    localparam int PW     = $clog2(POLL_CYC + 1);
    localparam int PH_MAX = (SETUP_CYC > GAP_CYC) ?
                            ((SETUP_CYC > TIMEOUT_CYC) ? SETUP_CYC : TIMEOUT_CYC) :
                            ((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC);
    localparam int CW     = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, GAP, DONE} state_e;

    state_e        state_q;
    logic [PW-1:0] poll_q, poll_d;
    logic [CW-1:0] ph_q;
    logic [2:0]    idx_q;
    logic [1:0]    led_q;
    logic [7:0]    x_lo_q, y_lo_q;
    logic [1:0]    x_hi_q, y_hi_q;
    logic          poll_expire;
    logic [9:0]    x_dec, y_dec;

    function automatic logic [9:0] dz(input logic [9:0] v);
`ifdef JSTK_DEADZONE_EN
        return (v >= 10'd480 && v <= 10'd520) ? 10'd500 : v;
`else
        return v;
`endif
    endfunction

    // Poll period runs independently of frame length; expiries outside IDLE are dropped.
    assign poll_expire = (poll_q == PW'(POLL_CYC - 1));
    assign poll_d      = poll_expire ? '0 : poll_q + PW'(1);

    assign x_dec = dz({x_hi_q, x_lo_q});
    assign y_dec = dz({y_hi_q, y_lo_q});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            poll_q         <= '0;
            ph_q           <= '0;
            idx_q          <= '0;
            led_q          <= '0;
            x_lo_q         <= '0;
            x_hi_q         <= '0;
            y_lo_q         <= '0;
            y_hi_q         <= '0;
            ss_o           <= 1'b1;
            spi_start_o    <= 1'b0;
            spi_tx_o       <= '0;
            velocity_o     <= 11'd500;
            steer_o        <= 10'd500;
            buttons_o      <= '0;
            sample_valid_o <= 1'b0;
            timeout_err_o  <= 1'b0;
        end else begin
            poll_q         <= poll_d;
            spi_start_o    <= 1'b0;
            sample_valid_o <= 1'b0;
            timeout_err_o  <= 1'b0;
            case (state_q)
                IDLE: if (poll_expire) begin
                    state_q <= SETUP;
                    ss_o    <= 1'b0;
                    idx_q   <= '0;
                    ph_q    <= '0;
                    led_q   <= led_cmd_i;
                end
                SETUP: if (ph_q == CW'(SETUP_CYC - 1)) begin
                    state_q     <= XFER;
                    spi_start_o <= 1'b1;
                    spi_tx_o    <= {6'b100000, led_q};
                end else begin
                    ph_q <= ph_q + CW'(1);
                end
                XFER: begin
                    state_q  <= WAIT;
                    ph_q     <= '0;
                    spi_tx_o <= '0;
                end
                WAIT: if (spi_done_i) begin
                    ph_q <= '0;
                    if (idx_q == 3'd4) begin
                        // Byte 4 goes straight to the outputs so the whole frame lands at once.
                        state_q        <= DONE;
                        ss_o           <= 1'b1;
                        sample_valid_o <= 1'b1;
                        velocity_o     <= {1'b0, x_dec};
                        steer_o        <= y_dec;
                        buttons_o      <= spi_rx_i[2:0];
                    end else begin
                        state_q <= GAP;
                        case (idx_q)
                            3'd0:    x_lo_q <= spi_rx_i;
                            3'd1:    x_hi_q <= spi_rx_i[1:0];
                            3'd2:    y_lo_q <= spi_rx_i;
                            default: y_hi_q <= spi_rx_i[1:0];
                        endcase
                    end
                end else if (ph_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_q       <= IDLE;
                    ss_o          <= 1'b1;
                    timeout_err_o <= 1'b1;
                end else begin
                    ph_q <= ph_q + CW'(1);
                end
                GAP: if (ph_q == CW'(GAP_CYC - 1)) begin
                    state_q     <= XFER;
                    idx_q       <= idx_q + 3'd1;
                    spi_start_o <= 1'b1;
                    spi_tx_o    <= 8'h00;
                end else begin
                    ph_q <= ph_q + CW'(1);
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/jstk_poll_ctrl.md
JSTK_POLL_CTRL -- requirements
Module: jstk_poll_ctrl

Interface
REQ-001 Parameter POLL_CYC, default 1_000_000, clock cycles between poll starts (10 ms at 100 MHz).
REQ-002 Parameter SETUP_CYC, default 1500, cycles from ss falling to first byte start (15 us).
REQ-003 Parameter GAP_CYC, default 1000, cycles between spi_done and next byte start (10 us).
REQ-004 Parameter TIMEOUT_CYC, default 4096, maximum cycles waiting for spi_done per byte.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 spi_start  out  1  one-cycle request to the SPI byte engine.
REQ-008 spi_tx  out  8  byte to transmit, valid while spi_start is high.
REQ-009 spi_done  in  1  one-cycle pulse; the byte engine has finished, spi_rx is valid.
REQ-010 spi_rx  in  8  byte received from the joystick.
REQ-011 ss  out  1  joystick slave select, active-low.
REQ-012 led_cmd  in  2  joystick LED request, sampled at poll start.
REQ-013 velocity  out  11  latest X axis value, zero-extended from 10 bits.
REQ-014 steer  out  10  latest Y axis value.
REQ-015 buttons  out  3  latest button bits {trigger, btn2, btn1}.
REQ-016 sample_valid  out  1  one-cycle pulse when velocity/steer/buttons are updated.
REQ-017 timeout_err  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, XFER, WAIT, GAP, DONE.
- IDLE: poll counter runs; at POLL_CYC-1 -> SETUP, ss<=0, byte index<=0, led_cmd latched.
- SETUP: hold SETUP_CYC cycles -> XFER.
- XFER: spi_start=1 for exactly one cycle with spi_tx -> WAIT.
- WAIT: spi_done -> store spi_rx in shadow byte[index]; index 4 -> DONE, else -> GAP.
- GAP: hold GAP_CYC cycles -> XFER, index+1.
- DONE: ss<=1, outputs updated, sample_valid=1 for one cycle -> IDLE.
REQ-019 spi_tx SHALL be {6'b100000, led_cmd_latched} for byte 0 and 8'h00 for bytes 1-4.
REQ-020 Decode: X = {byte1[1:0], byte0}, Y = {byte3[1:0], byte2}, buttons = byte4[2:0].
REQ-021 velocity, steer and buttons SHALL change only in the DONE cycle, all together; partial frames SHALL never reach the outputs.
REQ-022 The poll counter SHALL free-run from frame start, so the frame start period is exactly POLL_CYC cycles, independent of frame length.
REQ-023 If the counter expires while a frame is in progress, that poll SHALL be skipped (no queueing); the next start is at the following expiry.
REQ-024 In WAIT, if TIMEOUT_CYC cycles pass without spi_done: ss<=1, timeout_err pulses one cycle, outputs are kept, -> IDLE.
REQ-025 spi_done outside WAIT SHALL be ignored.
REQ-026 ss SHALL stay low continuously from SETUP entry to DONE or abort.

Reset
REQ-027 While rst=1: state IDLE, ss=1, spi_start=0, spi_tx=0, velocity=11'd500, steer=10'd500, buttons=0, sample_valid=0, timeout_err=0, counters=0.
REQ-028 rst asserted mid-frame SHALL abort the frame on the next clk edge, with no sample_valid and no timeout_err pulse.

Configuration
REQ-029 Macro JSTK_DEADZONE_EN: when defined, a decoded X or Y in 480..520 inclusive SHALL be output as 500; when undefined, raw values are output unchanged.

Verification
REQ-030 Bytes 0x2C,0x02,0xF4,0x01,0x05 -> velocity=556, steer=500, buttons=3'b101, one sample_valid, ss low throughout the frame.
REQ-031 With JSTK_DEADZONE_EN, X=0x1EA (490) -> velocity=500; without it -> velocity=490.
REQ-032 No spi_done on byte 2 -> timeout_err pulses TIMEOUT_CYC cycles after WAIT entry, ss=1, outputs unchanged, next frame at the next poll expiry.
REQ-033 rst pulsed during GAP of byte 3 -> ss=1 and reset values on the next edge, no sample_valid.
REQ-034 POLL_CYC=50 with a frame lasting longer than 50 cycles -> the overlapping expiry is skipped; frame starts are spaced exactly 100 cycles apart.
REQ-035 led_cmd=2'b11 -> spi_tx=8'h83 on byte 0 and 8'h00 on bytes 1-4; the led_cmd change mid-frame is not reflected until the next frame.
